// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the nano RV32I core.
// Produces datapath enables, memory-wait timeouts, retired count and sticky trap.
module rv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic             take_branch_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             branch_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             halted_o,
  output logic [2:0]       cause_o
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
  typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBr, ClsJal, ClsJalr, ClsNop} cls_e;

  state_e           r_state;
  cls_e             r_cls;
  logic [WaitW-1:0] r_wait;
  logic [2:0]       r_cause;
  logic [CNT_W-1:0] r_instret;

  cls_e       w_cls;
  logic [2:0] w_dec_cause;
  logic       w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_branch, w_pc_we, w_rf_we;
  logic       w_halted;
  logic [1:0] w_pc_sel, w_wb_sel;

  always_comb begin
    w_cls       = ClsNop;
    w_dec_cause = 3'd0;
    case (opcode_i)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: w_cls = ClsAlu;
      7'b0000011: w_cls = ClsLoad;
      7'b0100011: w_cls = ClsStore;
      7'b1100011: w_cls = ClsBr;
      7'b1101111: w_cls = ClsJal;
      7'b1100111: w_cls = ClsJalr;
      7'b0001111: w_cls = ClsNop;
      7'b1110011: w_dec_cause = 3'd4;
      default:    w_dec_cause = 3'd1;
    endcase
  end

  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_branch   = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 2'd0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 2'd0;
    w_halted   = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_imem_req = 1'b1;
        w_ir_we    = imem_ready_i;
      end
      StDecode: ;
      StExec: begin
        if (r_cls == ClsBr) begin
          w_branch = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_sel = take_branch_i ? 2'd1 : 2'd0;
        end else if (r_cls == ClsNop) begin
          w_pc_we = 1'b1;
        end
      end
      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_cls == ClsStore);
        w_pc_we    = dmem_ready_i && (r_cls == ClsStore);
      end
      StWb: begin
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        case (r_cls)
          ClsLoad: w_wb_sel = 2'd1;
          ClsJal: begin
            w_wb_sel = 2'd2;
            w_pc_sel = 2'd1;
          end
          ClsJalr: begin
            w_wb_sel = 2'd2;
            w_pc_sel = 2'd2;
          end
          default: ;
        endcase
      end
      StTrap: w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StFetch;
      r_cls     <= ClsAlu;
      r_wait    <= '0;
      r_cause   <= 3'd0;
      r_instret <= '0;
    end else begin
      if (w_pc_we) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        StFetch: begin
          if (imem_ready_i) begin
            r_wait  <= '0;
            r_state <= StDecode;
          end else if (r_wait == WaitLast) begin
            r_state <= StTrap;
            r_cause <= 3'd2;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StDecode: begin
          if (w_dec_cause != 3'd0) begin
            r_state <= StTrap;
            r_cause <= w_dec_cause;
          end else begin
            r_cls   <= w_cls;
            r_state <= StExec;
          end
        end
        StExec: begin
          case (r_cls)
            ClsBr, ClsNop:    r_state <= StFetch;
            ClsLoad, ClsStore: r_state <= StMem;
            default:          r_state <= StWb;
          endcase
        end
        StMem: begin
          if (dmem_ready_i) begin
            r_wait  <= '0;
            r_state <= (r_cls == ClsStore) ? StFetch : StWb;
          end else if (r_wait == WaitLast) begin
            r_state <= StTrap;
            r_cause <= 3'd3;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StWb:    r_state <= StFetch;
        StTrap:  r_state <= StTrap;
        default: r_state <= StFetch;
      endcase
    end
  end

  // Enables are forced low the moment reset asserts, without waiting for a clock.
  assign imem_req_o = rst_ni & w_imem_req;
  assign ir_we_o    = rst_ni & w_ir_we;
  assign dmem_req_o = rst_ni & w_dmem_req;
  assign dmem_we_o  = rst_ni & w_dmem_we;
  assign branch_o   = rst_ni & w_branch;
  assign pc_we_o    = rst_ni & w_pc_we;
  assign pc_sel_o   = rst_ni ? w_pc_sel : 2'd0;
  assign rf_we_o    = rst_ni & w_rf_we;
  assign wb_sel_o   = rst_ni ? w_wb_sel : 2'd0;
  assign halted_o   = rst_ni & w_halted;
  assign cause_o    = r_cause;
  assign instret_o  = r_instret;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-instruction transaction model builds expected
// cycle-by-cycle outputs from opcode, memory wait counts and branch decision.
module tb_rv_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;
  localparam int PcWeBit = 9;

  localparam int CAlu = 0, CLoad = 1, CStore = 2, CBr = 3, CJal = 4, CJalr = 5, CNop = 6;
  localparam int CSys = 7, CIll = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [6:0]    opcode_i;
  logic          take_branch_i, imem_ready_i, dmem_ready_i;
  logic          imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, branch_o, pc_we_o, rf_we_o;
  logic [1:0]    pc_sel_o, wb_sel_o;
  logic [CW-1:0] instret_o;
  logic          halted_o;
  logic [2:0]    cause_o;
  logic [14:0]   obs_vec;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] m_instret;
  bit            stopped;

  logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                                 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111,
                                 7'b0110011};

  rv_multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .opcode_i     (opcode_i),
    .take_branch_i(take_branch_i),
    .imem_ready_i (imem_ready_i),
    .dmem_ready_i (dmem_ready_i),
    .imem_req_o   (imem_req_o),
    .ir_we_o      (ir_we_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .branch_o     (branch_o),
    .pc_we_o      (pc_we_o),
    .pc_sel_o     (pc_sel_o),
    .rf_we_o      (rf_we_o),
    .wb_sel_o     (wb_sel_o),
    .instret_o    (instret_o),
    .halted_o     (halted_o),
    .cause_o      (cause_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs_vec = {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, branch_o, pc_we_o, pc_sel_o,
                    rf_we_o, wb_sel_o, halted_o, cause_o};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  function automatic logic [14:0] ev(input logic ireq, input logic irwe, input logic dreq,
                                     input logic dwe, input logic br, input logic pcwe,
                                     input logic [1:0] pcs, input logic rfwe,
                                     input logic [1:0] wbs, input logic hlt,
                                     input logic [2:0] cs);
    return {ireq, irwe, dreq, dwe, br, pcwe, pcs, rfwe, wbs, hlt, cs};
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return CAlu;
      7'b0000011: return CLoad;
      7'b0100011: return CStore;
      7'b1100011: return CBr;
      7'b1101111: return CJal;
      7'b1100111: return CJalr;
      7'b0001111: return CNop;
      7'b1110011: return CSys;
      default:    return CIll;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare just after it.
  task automatic cyc(input string tag, input logic ir, input logic dr, input logic tk,
                     input logic [6:0] op, input logic [14:0] exp);
    @(negedge clk_i);
    imem_ready_i  = ir;
    dmem_ready_i  = dr;
    take_branch_i = tk;
    opcode_i      = op;
    #1;
    check({tag, "/outputs"}, 32'(obs_vec), 32'(exp));
    check({tag, "/instret"}, 32'(instret_o), 32'(m_instret));
    if (exp[PcWeBit]) m_instret = m_instret + CW'(1);
  endtask

  task automatic hold_trap(input logic [2:0] cs);
    for (int i = 0; i < 2; i++) cyc("trap", rb(), rb(), rb(), ro(), ev(0,0,0,0,0,0,2'd0,0,2'd0,1,cs));
  endtask

  task automatic assert_reset();
    rst_ni = 1'b0;
    #1;
    check("reset/outputs", 32'(obs_vec), 32'd0);
    check("reset/instret", 32'(instret_o), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni    = 1'b1;
    m_instret = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    assert_reset();
    release_reset();
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic tk,
                           input bit abort_mem, output bit stop);
    int       c;
    logic     ready, st;
    logic [1:0] pcs, wbs;
    stop = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      ready = (i == fw);
      cyc("fetch", ready, rb(), rb(), ro(), ev(1,ready,0,0,0,0,2'd0,0,2'd0,0,3'd0));
      if (ready) break;
    end
    if (fw >= int'(TO)) begin
      hold_trap(3'd2);
      stop = 1'b1;
      return;
    end
    cyc("decode", rb(), rb(), rb(), op, 15'd0);
    c = cls_of(op);
    if (c == CSys || c == CIll) begin
      hold_trap((c == CSys) ? 3'd4 : 3'd1);
      stop = 1'b1;
      return;
    end
    if (c == CBr) begin
      cyc("exec_br", rb(), rb(), tk, op, ev(0,0,0,0,1,1,tk ? 2'd1 : 2'd0,0,2'd0,0,3'd0));
      return;
    end
    if (c == CNop) begin
      cyc("exec_nop", rb(), rb(), rb(), op, ev(0,0,0,0,0,1,2'd0,0,2'd0,0,3'd0));
      return;
    end
    cyc("exec", rb(), rb(), rb(), op, 15'd0);
    if (c == CLoad || c == CStore) begin
      st = (c == CStore);
      for (int i = 0; i < int'(TO); i++) begin
        ready = (i == mw);
        cyc("mem", rb(), ready, rb(), op, ev(0,0,1,st,0,ready & st,2'd0,0,2'd0,0,3'd0));
        if (abort_mem && i == 1) begin
          #2;
          assert_reset();
          stop = 1'b1;
          return;
        end
        if (ready) break;
      end
      if (mw >= int'(TO)) begin
        hold_trap(3'd3);
        stop = 1'b1;
        return;
      end
      if (st) return;
    end
    case (c)
      CLoad:   begin wbs = 2'd1; pcs = 2'd0; end
      CJal:    begin wbs = 2'd2; pcs = 2'd1; end
      CJalr:   begin wbs = 2'd2; pcs = 2'd2; end
      default: begin wbs = 2'd0; pcs = 2'd0; end
    endcase
    cyc("wb", rb(), rb(), rb(), op, ev(0,0,0,0,0,1,pcs,1,wbs,0,3'd0));
  endtask

  initial begin
    int   r, fw, mw;
    logic [6:0] op;
    rst_ni        = 1'b0;
    opcode_i      = '0;
    take_branch_i = 1'b0;
    imem_ready_i  = 1'b0;
    dmem_ready_i  = 1'b0;
    m_instret     = '0;
    do_reset();

    run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, stopped);  // ADD
    run_instr(7'b1100011, 0, 0, 1'b1, 1'b0, stopped);  // BEQ taken
    run_instr(7'b1100011, 0, 0, 1'b0, 1'b0, stopped);  // BEQ not taken
    run_instr(7'b0000011, 0, 3, 1'b0, 1'b0, stopped);  // LOAD, 3 waits
    run_instr(7'b0100011, 1, 0, 1'b0, 1'b0, stopped);  // STORE
    run_instr(7'b1101111, 0, 0, 1'b0, 1'b0, stopped);  // JAL
    run_instr(7'b1100111, 2, 0, 1'b0, 1'b0, stopped);  // JALR
    run_instr(7'b0001111, 0, 0, 1'b0, 1'b0, stopped);  // FENCE
    run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, stopped);  // illegal
    do_reset();
    run_instr(7'b0110011, 4, 0, 1'b0, 1'b0, stopped);  // fetch timeout
    do_reset();
    run_instr(7'b0110011, 3, 0, 1'b0, 1'b0, stopped);  // ready in last allowed cycle
    run_instr(7'b0000011, 0, 3, 1'b0, 1'b0, stopped);
    run_instr(7'b0000011, 0, 4, 1'b0, 1'b0, stopped);  // data timeout
    do_reset();
    run_instr(7'b1110011, 0, 0, 1'b0, 1'b0, stopped);  // SYSTEM
    do_reset();
    run_instr(7'b0000011, 0, 3, 1'b0, 1'b1, stopped);  // reset lands mid-MEM
    release_reset();
    run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, stopped);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 18)       op = legal_ops[r % 11];
      else if (r == 18) op = 7'b1110011;
      else              op = ro();
      fw = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      mw = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      run_instr(op, fw, mw, rb(), 1'b0, stopped);
      if (stopped) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle sequencer for the nano RV32I core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables for the IR, PC, register file and memory ports. In EXEC it qualifies the branch comparator (branch_o out, take_branch_i back) and selects the next PC. It also runs memory-wait timeouts, a retired-instruction counter and a sticky trap/halt state.

Parameters:
TIMEOUT, 16, max wait cycles for imem/dmem ready before trapping (must be >=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
opcode_i  in  7  IR[6:0]; valid from DECODE onward
take_branch_i  in  1  branch decision from comparator
imem_ready_i  in  1  instruction memory data valid
dmem_ready_i  in  1  data memory access complete
imem_req_o  out  1  instruction fetch request
ir_we_o  out  1  load IR
dmem_req_o  out  1  data access request
dmem_we_o  out  1  1 = store
branch_o  out  1  comparator enable (EXEC of BRANCH only)
pc_we_o  out  1  PC write (one pulse per retired instruction)
pc_sel_o  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1
rf_we_o  out  1  register file write
wb_sel_o  out  2  0 = ALU, 1 = memory, 2 = PC+4
instret_o  out  CNT_W  retired-instruction count
halted_o  out  1  in TRAP
cause_o  out  3  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout, 4 SYSTEM

Behaviour:
- Reset (async, any state): state = FETCH. All outputs 0, instret_o = 0, wait counter = 0, cause_o = 0. First imem_req_o is in the first clock after rst_ni rises.
- Outputs are Moore/Mealy combinational from state plus class plus ready. All outputs are 0 unless listed below.
- FETCH: imem_req_o = 1 held until imem_ready_i. In the ready cycle: ir_we_o = 1, go to DECODE, clear wait counter.
- DECODE: one cycle. Latch class from opcode_i:
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111 -> ALU
  - LOAD 0000011 -> LOAD; STORE 0100011 -> STORE; BRANCH 1100011 -> BR
  - JAL 1101111 -> JAL; JALR 1100111 -> JALR; FENCE 0001111 -> NOP
  - SYSTEM 1110011 -> TRAP with cause 4
  - any other opcode -> TRAP with cause 1
- EXEC: one cycle.
  - BR: branch_o = 1, pc_we_o = 1, pc_sel_o = take_branch_i ? 1 : 0, go to FETCH.
  - NOP: pc_we_o = 1, pc_sel_o = 0, go to FETCH.
  - LOAD/STORE: go to MEM.
  - ALU/JAL/JALR: go to WB.
- MEM: dmem_req_o = 1 and dmem_we_o = (STORE), held until dmem_ready_i.
  - In the ready cycle, STORE: pc_we_o = 1, pc_sel_o = 0, go to FETCH.
  - In the ready cycle, LOAD: go to WB.
  - Clear wait counter.
- WB: one cycle, rf_we_o = 1, pc_we_o = 1.
  - ALU: wb_sel_o = 0, pc_sel_o = 0.
  - LOAD: wb_sel_o = 1, pc_sel_o = 0.
  - JAL: wb_sel_o = 2, pc_sel_o = 1.
  - JALR: wb_sel_o = 2, pc_sel_o = 2.
  - Then go to FETCH.
- Timeout: the wait counter increments each FETCH/MEM cycle where ready is low. When the counter reaches TIMEOUT-1 and ready is still low, go to TRAP with cause 2 (FETCH) or 3 (MEM); req drops the next cycle. Ready arriving in exactly the TIMEOUT-th cycle counts as success.
- TRAP: halted_o = 1, cause_o held, all enables 0. Only reset exits. The PC is not updated for the trapping instruction and instret_o does not increment.
- instret_o increments by 1 on every cycle with pc_we_o = 1 and wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - BR/NOP: 3 cycles
  - ALU/JAL/JALR: 4 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- Invariants:
  - pc_we_o is never asserted together with imem_req_o.
  - rf_we_o only in WB.
  - branch_o only with class BR.
  - ready inputs are ignored outside their request states.

Test Plan:
- Reset, then ADD (0110011) with imem_ready_i tied 1 -> imem_req_o at cycle 1; ir_we_o at cycle 1; rf_we_o, pc_we_o, wb_sel_o = 0 at cycle 4; instret_o = 1.
- BEQ (1100011), take_branch_i = 1 then 0 on next BEQ -> branch_o = 1 only in EXEC; pc_sel_o = 1 then 0; no rf_we_o; instret_o += 2 over 6 cycles.
- LOAD with dmem_ready_i after 3 wait cycles -> dmem_req_o high for 4 cycles, dmem_we_o = 0, then WB with wb_sel_o = 1; STORE -> dmem_we_o = 1, no rf_we_o.
- JALR -> WB: rf_we_o = 1, wb_sel_o = 2, pc_sel_o = 2; opcode 1111111 -> halted_o = 1, cause_o = 1, instret_o unchanged.
- imem_ready_i held 0 with TIMEOUT = 4 -> TRAP after 4 request cycles, cause_o = 2; repeat with ready in 4th cycle -> no trap.
- Assert rst_ni low mid-MEM (dmem_req_o high) -> all outputs 0 immediately, asynchronously; after release, FETCH restarts and instret_o = 0.
